// File: rtl/bk_pipe_subtractor_if.sv
// bk_pipe_subtractor_if: operand/result handshake bundle for the pipelined subtractor
interface bk_pipe_subtractor_if #(parameter int WIDTH = 32);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic Bin;
  logic out_valid;
  logic out_ready;
  logic [WIDTH-1:0] Diff;
  logic Bout;
  logic Ovf;
  modport master (output in_valid, A, B, Bin, out_ready, input in_ready, out_valid, Diff, Bout, Ovf);
  modport slave (input in_valid, A, B, Bin, out_ready, output in_ready, out_valid, Diff, Bout, Ovf);
endinterface

// File: rtl/bk_pipe_subtractor.sv
// bk_pipe_subtractor: 3-stage valid/ready A-B-Bin subtractor on a Brent-Kung prefix carry tree
module bk_pipe_subtractor #(parameter int WIDTH = 32) (
  input logic clk,
  input logic rst_n,
  bk_pipe_subtractor_if.slave bus
);
  localparam int LG = $clog2(WIDTH);
  logic v1, v2, v3, en1, en2, en3, c1, ne2, am2, b3, o3;
  logic [WIDTH-1:0] g1, p1, p2, gg, pp, d3;
  logic [WIDTH:0] c2;
  assign en3 = ~v3 | bus.out_ready;
  assign en2 = ~v2 | en3;
  assign en1 = ~v1 | en2;
  assign bus.in_ready = rst_n & en1;
  assign bus.out_valid = v3;
  assign bus.Diff = d3;
  assign bus.Bout = b3;
  assign bus.Ovf = o3;
  // Carry-in folded into bit 0, so gg ends up as the carry out of every bit
  always_comb begin
    gg = {g1[WIDTH-1:1], g1[0] | (p1[0] & c1)};
    pp = p1;
    for (int l = 0; l < LG; l++)
      for (int i = (2 << l) - 1; i < WIDTH; i += 2 << l) begin
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
        pp[i] = pp[i] & pp[i - (1 << l)];
      end
    for (int l = LG - 2; l >= 0; l--)
      for (int i = 3 * (1 << l) - 1; i < WIDTH; i += 2 << l)
        gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
  end
  // Operand MSBs differ exactly when the MSB propagate is 0, and then A's MSB equals the MSB generate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      g1 <= '0;
      p1 <= '0;
      c1 <= 1'b0;
      p2 <= '0;
      c2 <= '0;
      ne2 <= 1'b0;
      am2 <= 1'b0;
      d3 <= '0;
      b3 <= 1'b0;
      o3 <= 1'b0;
    end else begin
      if (en1) begin
        v1 <= bus.in_valid;
        g1 <= bus.A & ~bus.B;
        p1 <= bus.A ^ ~bus.B;
        c1 <= ~bus.Bin;
      end
      if (en2) begin
        v2 <= v1;
        p2 <= p1;
        c2 <= {gg, c1};
        ne2 <= ~p1[WIDTH-1];
        am2 <= g1[WIDTH-1];
      end
      if (en3) begin
        v3 <= v2;
        d3 <= p2 ^ c2[WIDTH-1:0];
        b3 <= ~c2[WIDTH];
        o3 <= ne2 & (p2[WIDTH-1] ^ c2[WIDTH-1] ^ am2);
      end
    end
  end
endmodule

// File: doc/bk_pipe_subtractor.md
BK_PIPE_SUBTRACTOR -- requirements
Module: bk_pipe_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal values are powers of two from 4 to 64.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the operand set is present.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-006 The block SHALL have port A, input, WIDTH bits: the minuend.
REQ-007 The block SHALL have port B, input, WIDTH bits: the subtrahend.
REQ-008 The block SHALL have port Bin, input, 1 bit: the borrow-in.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a result is present.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream accepts the result.
REQ-011 The block SHALL have port Diff, output, WIDTH bits: (A - B - Bin) mod 2^WIDTH.
REQ-012 The block SHALL have port Bout, output, 1 bit: unsigned borrow-out.
REQ-013 The block SHALL have port Ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-014 Arithmetic SHALL be A + ~B + ~Bin, computed with a Brent-Kung parallel-prefix carry network; Bout SHALL be the inverse of the carry-out.
REQ-015 Bout SHALL be 1 exactly when A < B + Bin (unsigned, evaluated in WIDTH+1 bits).
REQ-016 Ovf SHALL be 1 exactly when A[MSB] != B[MSB] and Diff[MSB] != A[MSB].
REQ-017 The datapath SHALL have three registered stages, each with its own valid bit:
- S1 holds bitwise generate/propagate of A and ~B, plus ~Bin.
- S2 holds the prefix-tree group carries.
- S3 holds Diff, Bout and Ovf.
REQ-018 A transfer SHALL occur on the input when in_valid and in_ready are both 1 at a clock edge, and on the output when out_valid and out_ready are both 1.
REQ-019 With out_ready held at 1, a result SHALL appear with out_valid=1 exactly 3 cycles after its input transfer edge; throughput SHALL be one result per cycle.
REQ-020 A stage SHALL load when it is empty or when its contents advance in the same cycle.
REQ-021 in_ready SHALL equal (NOT S1 valid) OR S1 advancing; it may depend combinationally on out_ready.
REQ-022 When out_valid=1 and out_ready=0, the block SHALL hold Diff, Bout and Ovf stable.
REQ-023 Under backpressure the block SHALL hold at most 3 results, with no loss, duplication or reordering.
REQ-024 Outputs SHALL change only on a clock edge or on reset; there is no combinational path from A, B or Bin to any output.
REQ-025 When in_valid=0, bubbles SHALL propagate and out_valid SHALL be 0 for the matching cycles.
REQ-026 When the pipeline is full and out_ready=0, in_ready SHALL be 0 and the operands presented SHALL NOT be captured.

Reset
REQ-027 While rst_n=0, all stage valid bits SHALL clear immediately (asynchronously), giving out_valid=0, Diff=0, Bout=0 and Ovf=0.
REQ-028 While rst_n=0, in_ready SHALL be 0.
REQ-029 in_ready SHALL become 1 in the first cycle after rst_n deasserts.
REQ-030 A reset mid-operation SHALL discard all in-flight results; none SHALL emerge after reset.

Verification
REQ-031 The bench SHALL cover these directed scenarios (WIDTH=32, out_ready=1 unless stated):
- A=5, B=3, Bin=0 -> Diff=00000002, Bout=0, Ovf=0, 3 cycles after the transfer.
- A=0, B=1, Bin=0 -> Diff=FFFFFFFF, Bout=1, Ovf=0. Then A=0, B=0, Bin=1 -> Diff=FFFFFFFF, Bout=1.
- A=80000000, B=1, Bin=0 -> Diff=7FFFFFFF, Bout=0, Ovf=1. Then A=7FFFFFFF, B=FFFFFFFF -> Diff=80000000, Bout=1, Ovf=1.
- Backpressure: out_ready=0 while 4 back-to-back in_valid operand sets are presented -> 3 are accepted and in_ready=0 on the 4th. Then out_ready=1 -> 4 results in input order, and out_valid held constant while stalled.
- Reset mid-stream: 2 operand sets in flight, rst_n=0 for one cycle -> out_valid=0 immediately, and no stale result appears afterwards.
- Random: 1000 random A, B and Bin values with random out_ready -> every {Bout, Diff} matches a {1'b0, A} - B - Bin golden model, and every Ovf matches REQ-016.
